// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmitter arbiter.
// Optional header byte per packet is enabled with the UART_ARB_HDR_EN macro.
package uart_arb_pkg;

  // Arbiter states; HDR is only entered when header bytes are enabled.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HDR     = 3'd1,
    SEND    = 3'd2,
    WAIT_HI = 3'd3,
    WAIT_LO = 3'd4
  } arb_state_t;

  // Default base value for the per-packet header byte.
  localparam logic [7:0] HDR_BASE_DEFAULT = 8'hA0;

  // Cycles after tx_start within which tx_busy must rise before the byte
  // is treated as done anyway.
  localparam int BUSY_RISE_TIMEOUT = 2;
  localparam int BUSY_CNT_W        = 2;

  // Index width for a requester count; never below one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational rotate-priority picker: returns the first set request at or
// after the pointer, wrapping from the top index back to 0.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] pick_onehot,
  output logic [IDX_W-1:0]   pick_idx,
  output logic               pick_any
);

  logic             found_hi;
  logic [IDX_W-1:0] idx_hi;
  logic [IDX_W-1:0] idx_lo;

  // Lowest set index at/above the pointer wins; otherwise the lowest set
  // index overall (all of which lie below the pointer) is the wrapped winner.
  always_comb begin
    found_hi = 1'b0;
    idx_hi   = '0;
    idx_lo   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx_lo = IDX_W'(i);
        if (IDX_W'(i) >= ptr) begin
          idx_hi   = IDX_W'(i);
          found_hi = 1'b1;
        end
      end
    end
  end

  // Select the winner and expand it to one-hot.
  always_comb begin
    pick_any    = |req;
    pick_idx    = found_hi ? idx_hi : idx_lo;
    pick_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pick_onehot[i] = pick_any && (IDX_W'(i) == pick_idx);
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART byte transmitter between NUM_REQ
// packet sources. A grant is held for a whole packet (until the byte flagged
// last, or until the source drops its request), and each byte is sequenced
// over the transmitter's tx_start / tx_busy handshake.
// Macro UART_ARB_HDR_EN: when defined, every packet is preceded by the byte
// HDR_BASE | grant index, sent without a req_ack.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int         NUM_REQ  = 4,
  parameter logic [7:0] HDR_BASE = HDR_BASE_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ack,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy
);

  localparam int IDX_W = idx_width(NUM_REQ);

  arb_state_t              state_q, state_d;
  logic [IDX_W-1:0]        gidx_q, gidx_d;
  logic [IDX_W-1:0]        ptr_q, ptr_d;
  logic [IDX_W-1:0]        ptr_next;
  logic                    last_q, last_d;
  logic [BUSY_CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0]      grant_d;
  logic [NUM_REQ-1:0]      req_ack_d;
  logic                    tx_start_d;
  logic [7:0]              tx_data_d;
  logic                    byte_done;

  logic [NUM_REQ-1:0]      pick_onehot;
  logic [IDX_W-1:0]        pick_idx;
  logic                    pick_any;

  logic [7:0]              req_bytes [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_bytes
    assign req_bytes[i] = req_data[8*i +: 8];
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req         (req),
    .ptr         (ptr_q),
    .pick_onehot (pick_onehot),
    .pick_idx    (pick_idx),
    .pick_any    (pick_any)
  );

  // Explicit wrap so non-power-of-two requester counts stay in range.
  assign ptr_next = (gidx_q == IDX_W'(NUM_REQ - 1)) ? '0 : gidx_q + 1'b1;

  // Next-state, grant bookkeeping and the registered tx/ack pulses.
  always_comb begin
    state_d    = state_q;
    gidx_d     = gidx_q;
    ptr_d      = ptr_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    grant_d    = grant;
    req_ack_d  = '0;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data;
    byte_done  = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d = pick_onehot;
          gidx_d  = pick_idx;
`ifdef UART_ARB_HDR_EN
          state_d = HDR;
`else
          state_d = SEND;
`endif
        end
      end

      // Reachable only when header bytes are enabled.
      HDR: begin
        if (!tx_busy) begin
          tx_start_d = 1'b1;
          tx_data_d  = HDR_BASE | 8'(gidx_q);
          last_d     = 1'b0;
          cnt_d      = '0;
          state_d    = WAIT_HI;
        end
      end

      SEND: begin
        if (!tx_busy) begin
          if (req[gidx_q]) begin
            tx_start_d        = 1'b1;
            tx_data_d         = req_bytes[gidx_q];
            req_ack_d[gidx_q] = 1'b1;
            last_d            = req_last[gidx_q];
            cnt_d             = '0;
            state_d           = WAIT_HI;
          end else begin
            // Source withdrew mid-packet: release and move past it.
            grant_d = '0;
            ptr_d   = ptr_next;
            state_d = IDLE;
          end
        end
      end

      WAIT_HI: begin
        if (tx_busy) begin
          state_d = WAIT_LO;
        end else if (cnt_q == BUSY_CNT_W'(BUSY_RISE_TIMEOUT)) begin
          // Transmitter never acknowledged; carry on rather than hang.
          byte_done = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      WAIT_LO: begin
        if (!tx_busy) begin
          byte_done = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    if (byte_done) begin
      if (last_q) begin
        grant_d = '0;
        ptr_d   = ptr_next;
        state_d = IDLE;
      end else begin
        state_d = SEND;
      end
    end
  end

  // State and output registers; reset abandons any byte in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      gidx_q   <= '0;
      ptr_q    <= '0;
      last_q   <= 1'b0;
      cnt_q    <= '0;
      grant    <= '0;
      req_ack  <= '0;
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      state_q  <= state_d;
      gidx_q   <= gidx_d;
      ptr_q    <= ptr_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      grant    <= grant_d;
      req_ack  <= req_ack_d;
      tx_start <= tx_start_d;
      tx_data  <= tx_data_d;
    end
  end

endmodule
